// File: rtl/display_pkg.sv
// Shared types and helpers for the score-tile display sequencer.
package display_pkg;

  typedef enum logic [1:0] {
    S_END  = 2'd0,
    S_PLAY = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam int unsigned TILES_DEFAULT = 12;

  // Number of tiles a score earns, saturating at the tile count.
  function automatic logic [31:0] sat_target(input logic [31:0] score, input int unsigned tiles);
    logic [31:0] t;
    t = 32'(tiles);
    return (score >= t) ? t : score;
  endfunction

endpackage

// File: rtl/display_sequencer_frame_divider.sv
// Enable-gated frame counter: advances on each tick, pulses tc_c on the wrapping tick.
module frame_divider #(
  parameter int unsigned MAX = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned W = (MAX > 1) ? $clog2(MAX) : 1;

  logic [W-1:0] count;
  logic         at_max;

  assign at_max = (count == W'(MAX - 1));
  assign tc_c   = tick && en && at_max;

  // A disabled tick parks the counter at zero so the next enable starts a full period.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (tick) begin
      if (!en || at_max) count <= '0;
      else               count <= count + W'(1);
    end
  end

endmodule

// File: rtl/display_sequencer.sv
// Frame-synchronous tile reveal and screen-select sequencer.
// Optional newest-tile blink enabled by defining DISPLAY_SEQ_BLINK_EN.
module display_sequencer
  import display_pkg::*;
#(
  parameter int unsigned TILES           = TILES_DEFAULT,
  parameter int unsigned FRAMES_PER_TILE = 8,
  parameter int unsigned HOLD_FRAMES     = 60,
  parameter int unsigned CNT_W           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             screenEnd,
  input  logic             ingame,
  input  logic [31:0]      score,
  output logic [TILES-1:0] reveal_mask,
  output logic             show_game,
  output logic [CNT_W-1:0] revealed_count,
  output logic             busy,
  output logic             all_done
);

  state_t           state, state_n;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] count_n;
  logic [TILES-1:0] mask_n;
  logic [TILES-1:0] mask_d;
  logic             all_done_n;
  logic             reveal_step;
  logic             rev_en, rev_tc_c;
  logic             hold_en, hold_tc_c;

  assign target  = CNT_W'(sat_target(score, TILES));
  assign busy    = (state == S_PLAY) && (revealed_count != target);
  assign rev_en  = (state == S_PLAY) && ingame && (revealed_count < target);
  assign hold_en = (state == S_HOLD) && !ingame;

  frame_divider #(.MAX(FRAMES_PER_TILE)) u_reveal_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (screenEnd),
    .en    (rev_en),
    .tc_c  (rev_tc_c)
  );

  frame_divider #(.MAX(HOLD_FRAMES)) u_hold_timer (
    .clk   (clk),
    .reset (reset),
    .tick  (screenEnd),
    .en    (hold_en),
    .tc_c  (hold_tc_c)
  );

  // Next state and reveal count; everything moves only on a frame boundary.
  always_comb begin
    state_n     = state;
    count_n     = revealed_count;
    all_done_n  = 1'b0;
    reveal_step = 1'b0;
    unique case (state)
      S_END: begin
        if (screenEnd && ingame) begin
          state_n = S_PLAY;
          count_n = '0;
        end
      end
      S_PLAY: begin
        if (screenEnd) begin
          if (!ingame) begin
            state_n = S_HOLD;
          end else if (revealed_count > target) begin
            count_n = target;
          end else if (rev_tc_c) begin
            count_n     = revealed_count + CNT_W'(1);
            reveal_step = 1'b1;
            all_done_n  = (revealed_count == CNT_W'(TILES - 1));
          end
        end
      end
      S_HOLD: begin
        if (screenEnd) begin
          if (ingame) begin
            state_n = S_PLAY;
            count_n = '0;
          end else if (hold_tc_c) begin
            state_n = S_END;
          end
        end
      end
      default: state_n = S_END;
    endcase
  end

  // Thermometer code of the next count.
  always_comb begin
    mask_n = '0;
    for (int unsigned i = 0; i < TILES; i++) begin
      mask_n[i] = (CNT_W'(i) < count_n);
    end
  end

`ifdef DISPLAY_SEQ_BLINK_EN
  logic [3:0] blink_cnt, blink_cnt_n;
  logic       blink_on, blink_on_n;

  // 16-frame window after each reveal; the newest tile is dark while bit 2 is set.
  always_comb begin
    blink_cnt_n = blink_cnt;
    blink_on_n  = blink_on;
    if (reveal_step) begin
      blink_cnt_n = 4'd0;
      blink_on_n  = 1'b1;
    end else if (screenEnd) begin
      if (state != S_PLAY || state_n != S_PLAY || count_n != revealed_count) begin
        blink_on_n = 1'b0;
      end else if (blink_on) begin
        if (blink_cnt == 4'd15) blink_on_n  = 1'b0;
        else                    blink_cnt_n = blink_cnt + 4'd1;
      end
    end
    mask_d = mask_n;
    for (int unsigned i = 0; i < TILES; i++) begin
      if (blink_on_n && blink_cnt_n[2] && (CNT_W'(i + 1) == count_n)) mask_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt <= 4'd0;
      blink_on  <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_n;
      blink_on  <= blink_on_n;
    end
  end
`else
  assign mask_d = mask_n;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= S_END;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      revealed_count <= '0;
      reveal_mask    <= '0;
      show_game      <= 1'b0;
      all_done       <= 1'b0;
    end else begin
      revealed_count <= count_n;
      reveal_mask    <= mask_d;
      show_game      <= (state_n != S_END);
      all_done       <= all_done_n;
    end
  end

endmodule

// File: tb/tb_display_sequencer.sv
// Randomized self-checking bench for display_sequencer against a frame-level model.
module tb_display_sequencer;

  localparam int unsigned TILES = 12;
  localparam int unsigned FPT   = 2;
  localparam int unsigned HOLD  = 3;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             screenEnd = 1'b0;
  logic             ingame = 1'b0;
  logic [31:0]      score = '0;
  logic [TILES-1:0] reveal_mask;
  logic             show_game;
  logic [CNT_W-1:0] revealed_count;
  logic             busy;
  logic             all_done;

  int errors = 0;
  int checks = 0;

  // Model: mode 0 = end screen, 1 = playing, 2 = holding game screen.
  int m_mode = 0;
  int m_cnt  = 0;
  int m_wait = 0;
  int m_hold = 0;
  bit m_done = 1'b0;
  int done_pulses = 0;

  always #5 clk = ~clk;

  display_sequencer #(
    .TILES           (TILES),
    .FRAMES_PER_TILE (FPT),
    .HOLD_FRAMES     (HOLD),
    .CNT_W           (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .screenEnd      (screenEnd),
    .ingame         (ingame),
    .score          (score),
    .reveal_mask    (reveal_mask),
    .show_game      (show_game),
    .revealed_count (revealed_count),
    .busy           (busy),
    .all_done       (all_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int tgt(input logic [31:0] s);
    return (s >= 32'(TILES)) ? int'(TILES) : int'(s);
  endfunction

  // One frame boundary of the reference behaviour.
  task automatic model_frame();
    m_done = 1'b0;
    case (m_mode)
      0: if (ingame) begin m_mode = 1; m_cnt = 0; m_wait = FPT; end
      1: begin
        if (!ingame) begin
          m_mode = 2; m_hold = HOLD;
        end else if (m_cnt > tgt(score)) begin
          m_cnt = tgt(score); m_wait = FPT;
        end else if (m_cnt == tgt(score)) begin
          m_wait = FPT;
        end else begin
          m_wait--;
          if (m_wait == 0) begin
            m_cnt++;
            m_wait = FPT;
            m_done = (m_cnt == int'(TILES));
          end
        end
      end
      default: begin
        if (ingame) begin
          m_mode = 1; m_cnt = 0; m_wait = FPT;
        end else begin
          m_hold--;
          if (m_hold == 0) m_mode = 0;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("mask", 32'(reveal_mask), (32'd1 << m_cnt) - 32'd1);
    chk("show_game", 32'(show_game), 32'(m_mode != 0));
    chk("count", 32'(revealed_count), 32'(m_cnt));
    chk("busy", 32'(busy), 32'((m_mode == 1) && (m_cnt != tgt(score))));
    chk("all_done", 32'(all_done), 32'(m_done));
    if (all_done) done_pulses++;
  endtask

  task automatic cycle(input logic se);
    screenEnd = se;
    @(posedge clk);
    if (!reset) begin
      m_mode = 0; m_cnt = 0; m_done = 1'b0;
    end else if (se) begin
      model_frame();
    end else begin
      m_done = 1'b0;
    end
    #1;
    screenEnd = 1'b0;
    compare_all();
  endtask

  task automatic frame(input int len);
    cycle(1'b1);
    for (int i = 1; i < len; i++) cycle(1'b0);
  endtask

  initial begin
    logic [TILES-1:0] saved_mask;

    // Reset held across frame pulses
    reset = 1'b0; ingame = 1'b1; score = 32'd5;
    repeat (5) cycle(1'b1);
    chk("rst_mask", 32'(reveal_mask), 32'd0);
    chk("rst_show", 32'(show_game), 32'd0);
    chk("rst_done", 32'(all_done), 32'd0);

    // Start and reveal three tiles
    reset = 1'b1; ingame = 1'b1; score = 32'd3;
    for (int f = 1; f <= 8; f++) begin
      frame(3);
      if (f == 1) chk("start_show", 32'(show_game), 32'd1);
      if (f == 3) chk("mask_f3", 32'(reveal_mask), 32'h001);
      if (f == 5) chk("mask_f5", 32'(reveal_mask), 32'h003);
      if (f == 7) begin
        chk("mask_f7", 32'(reveal_mask), 32'h007);
        chk("busy_f7", 32'(busy), 32'd0);
      end
    end

    // Saturation with exactly one all_done
    score = 32'd100; done_pulses = 0;
    repeat (40) frame(3);
    chk("sat_count", 32'(revealed_count), 32'd12);
    chk("sat_mask", 32'(reveal_mask), 32'hFFF);
    chk("sat_pulses", 32'(done_pulses), 32'd1);

    // Score drop
    score = 32'd5; frame(3);
    chk("drop_cnt5", 32'(revealed_count), 32'd5);
    score = 32'd2; frame(3);
    chk("drop_mask", 32'(reveal_mask), 32'h003);

    // Hold then end screen
    ingame = 1'b0;
    for (int f = 1; f <= 4; f++) begin
      frame(3);
      chk("hold_show", 32'(show_game), (f <= 3) ? 32'd1 : 32'd0);
    end

    // Re-entry during hold
    ingame = 1'b1; score = 32'd4;
    repeat (10) frame(3);
    ingame = 1'b0;
    frame(3); frame(3);
    ingame = 1'b1;
    frame(3);
    chk("reenter_show", 32'(show_game), 32'd1);
    chk("reenter_mask", 32'(reveal_mask), 32'd0);

    // Tear-free: score changes between boundaries
    repeat (4) frame(3);
    saved_mask = reveal_mask;
    cycle(1'b0);
    saved_mask = reveal_mask;
    score = 32'd0; cycle(1'b0);
    score = 32'd11; cycle(1'b0);
    chk("tear_mask", 32'(reveal_mask), 32'(saved_mask));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) ingame = ~ingame;
      if ($urandom_range(0, 3) == 0)
        score = ($urandom_range(0, 5) == 0) ? $urandom() : 32'($urandom_range(0, 14));
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b0;
        cycle(1'b1);
        reset = 1'b1;
      end
      cycle(1'b1);
      for (int c = 0; c < int'($urandom_range(1, 4)); c++) begin
        if ($urandom_range(0, 3) == 0) score = 32'($urandom_range(0, 14));
        cycle(1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
- Frame-synchronous controller that sequences the 4x3 score-tile display and the game/end-screen selection.
- Converts `ingame` and `score` into a registered per-tile reveal mask, revealing tiles one at a time at a fixed frame cadence.
- Drives the screen-source select, with a hold period before switching to the end screen.
- Sits between game logic and VGA colour muxing; all visible changes occur only on `screenEnd`, so the picture never tears.

Parameters:
- TILES, 12, number of score tiles (mask width).
- FRAMES_PER_TILE, 8, frames between successive tile reveals (>=1).
- HOLD_FRAMES, 60, frames the game screen is held after `ingame` falls (>=1).
- CNT_W, 4, width of `revealed_count`; must satisfy 2^CNT_W > TILES.

Ports:
- clk  in  1  pixel clock; same clock as the VGA timing generator.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- screenEnd  in  1  one-cycle pulse between frames, from the timing generator.
- ingame  in  1  level, game-running flag.
- score  in  32  unsigned score.
- reveal_mask  out  TILES  bit i=1 means tile i shows tile art; tile 0 is top-left, row-major.
- show_game  out  1  1 = tile screen, 0 = end screen.
- revealed_count  out  CNT_W  number of tiles currently revealed.
- busy  out  1  1 while in PLAY and `revealed_count` != target.
- all_done  out  1  one-cycle pulse when `revealed_count` becomes TILES.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=S_END, revealed_count=0, frame timer=0, hold counter=0.
  - reveal_mask=0, show_game=0, busy=0, all_done=0.
  - Reset overrides `screenEnd` in the same cycle.
- target = min(score, TILES), combinational, unsigned. Score >= TILES saturates.
- Every state/counter update happens only in a cycle where screenEnd==1. Outputs are registered and change one clk after that `screenEnd` cycle. Between frames all outputs are stable.
- S_END (show_game=0):
  - ingame==1 at `screenEnd` -> S_PLAY; revealed_count=0; timer=0.
- S_PLAY (show_game=1):
  - If revealed_count < target: timer increments per `screenEnd`. When timer==FRAMES_PER_TILE-1, timer wraps to 0 and revealed_count++ (+1 per step only).
  - If revealed_count == target: timer held at 0.
  - If revealed_count > target (score dropped): revealed_count=target and timer=0 at that `screenEnd`.
  - ingame==0 at `screenEnd` -> S_HOLD; hold counter=0. The reveal counter is frozen in S_HOLD.
- S_HOLD (show_game=1):
  - Hold counter increments per `screenEnd`. When it reaches HOLD_FRAMES-1 -> S_END.
  - ingame==1 at `screenEnd` -> S_PLAY with revealed_count=0 (new game).
- reveal_mask[i] = (i < revealed_count), registered in the same update as `revealed_count`. In S_END the mask keeps its last value; it is don't-care to the consumer.
- Latency: with FRAMES_PER_TILE=N and score stepping from k to k+1, tile k reveals on the Nth `screenEnd` after the step is seen.
- all_done: pulses on the cycle after the update that moves revealed_count from TILES-1 to TILES. It is not re-pulsed while revealed_count stays at TILES.
- busy: combinational from registered state and target; 0 outside S_PLAY.
- Reset asserted mid-reveal or mid-hold: immediate return to reset values at that clk edge.

Optional Feature:
- Macro DISPLAY_SEQ_BLINK_EN.
- Defined: for 16 frames after each reveal step, the newest revealed tile's mask bit is forced 0 on frames where (frames since reveal)[2]==1, giving a 4-on/4-off blink. A new reveal restarts the window. Leaving S_PLAY cancels the blink. This needs a 4-bit blink counter.
- Undefined: reveal_mask is exactly the thermometer code of `revealed_count`; no blink logic is synthesised.

Decomposition:
- Shared package `display_pkg` holds:
  - state encoding (S_END=2'd0, S_PLAY=2'd1, S_HOLD=2'd2);
  - TILES_DEFAULT=12;
  - function `sat_target(score, tiles)`.
- One natural sub-module: `frame_divider`, an enable-gated counter ticking on `screenEnd` with a terminal-count pulse. It is instantiated twice: the reveal timer and the hold timer.

Test Plan:
- Reset: hold reset=0 for 5 cycles while screenEnd pulses -> all outputs 0 and state S_END.
- Start+reveal: FRAMES_PER_TILE=2; ingame=1, score=3.
  - show_game=1 after 1st `screenEnd`.
  - Mask becomes 12'h001, 12'h003, 12'h007 after `screenEnd` #3, #5, #7.
  - busy drops to 0 when mask reaches 12'h007.
- Saturation: score=100 -> revealed_count stops at 12, mask 12'hFFF; exactly one all_done pulse; no further change over 20 frames.
- Score drop: score 5 -> 2 at count=5 -> next `screenEnd` gives mask 12'h003 and timer=0.
- Hold/re-entry: HOLD_FRAMES=3; ingame falls -> show_game stays 1 for 3 `screenEnd`s, then 0.
  - Repeat, raising ingame at the 2nd hold frame -> returns to S_PLAY with mask 0.
- Tear-free: change score mid-frame with no `screenEnd` -> outputs unchanged until the next `screenEnd`.
  - With DISPLAY_SEQ_BLINK_EN defined: the newest tile bit toggles every 4 frames for 16 frames.
